// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode and ALU encodings plus the decoded control bundle.
// Imported by the fetch/decode front end, the datapath and the hazard logic.
package cpu_pkg;

  typedef enum logic [2:0] {
    OpAdd = 3'b000,
    OpSub = 3'b001,
    OpAnd = 3'b010,
    OpOr  = 3'b011,
    OpLw  = 3'b100,
    OpSw  = 3'b101,
    OpBeq = 3'b110,
    OpJ   = 3'b111
  } opcode_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOr  = 3'b011
  } alu_op_e;

  typedef struct packed {
    alu_op_e alu_op;
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    logic    reg_dst;
    logic    branch;
    logic    jump;
  } ctrl_t;

  localparam ctrl_t CtrlBubble = '0;

  function automatic opcode_e opcode_of(logic [7:0] instr);
    return opcode_e'(instr[7:5]);
  endfunction

endpackage

// File: rtl/fetch_decode_if.sv
// Bundle between the datapath/loader (master) and the fetch/decode stage (slave).
interface fetch_decode_if #(
  parameter int unsigned CNT_W = 16
);
  logic [7:0]       pc;
  logic             stall;
  logic             flush;
  logic             prog_we;
  logic [7:0]       prog_addr;
  logic [7:0]       prog_data;
  logic [7:0]       instruction;
  logic [2:0]       alu_op;
  logic             reg_write;
  logic             mem_to_reg;
  logic             mem_read;
  logic             mem_write;
  logic             alu_src;
  logic             reg_dst;
  logic             branch;
  logic             jump;
  logic             valid;
  logic [CNT_W-1:0] fetch_count;

  modport master (
    output pc, stall, flush, prog_we, prog_addr, prog_data,
    input  instruction, alu_op, reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst,
           branch, jump, valid, fetch_count
  );

  modport slave (
    input  pc, stall, flush, prog_we, prog_addr, prog_data,
    output instruction, alu_op, reg_write, mem_to_reg, mem_read, mem_write, alu_src, reg_dst,
           branch, jump, valid, fetch_count
  );
endinterface

// File: rtl/instr_decoder.sv
// Combinational decode of an 8-bit instruction into the datapath control bundle.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [7:0] instruction,
  output ctrl_t      ctrl
);

  opcode_e opcode;
  logic    unused_operand;

  // Operand fields are consumed by the datapath, not by control decode.
  assign unused_operand = ^instruction[4:0];

  always_comb begin
    ctrl   = CtrlBubble;
    opcode = opcode_of(instruction);
    unique case (opcode)
      OpAdd, OpSub, OpAnd, OpOr: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.alu_op    = alu_op_e'(opcode);
      end
      OpLw: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.mem_read   = 1'b1;
        ctrl.alu_src    = 1'b1;
        ctrl.alu_op     = AluAdd;
      end
      OpSw: begin
        ctrl.mem_write = 1'b1;
        ctrl.alu_src   = 1'b1;
        ctrl.alu_op    = AluAdd;
      end
      OpBeq: begin
        ctrl.branch = 1'b1;
        ctrl.alu_op = AluSub;
      end
      OpJ: begin
        ctrl.jump   = 1'b1;
        ctrl.alu_op = AluAdd;
      end
      default: ctrl = CtrlBubble;
    endcase
  end

endmodule

// File: rtl/fetch_decode.sv
// Front-end stage: instruction memory, pre-register decode, IF/ID register and fetch counter.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned CNT_W      = 16
) (
  input logic           clk,
  input logic           reset,
  fetch_decode_if.slave bus
);

  localparam int unsigned AW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;

  logic [7:0]       mem [IMEM_DEPTH];
  logic [7:0]       fetch_word;
  ctrl_t            fetch_ctrl;
  logic [7:0]       instr_q;
  ctrl_t            ctrl_q;
  logic             valid_q;
  logic [CNT_W-1:0] cnt_q;

  // Addresses past the array read as 8'h00, which still decodes as a valid ADD.
  always_comb begin
    fetch_word = 8'h00;
    if (32'(bus.pc) < IMEM_DEPTH) begin
      fetch_word = mem[bus.pc[AW-1:0]];
    end
  end

  // Program port is deliberately outside reset so loaded code survives a reset.
  always_ff @(posedge clk) begin
    if (bus.prog_we && (32'(bus.prog_addr) < IMEM_DEPTH)) begin
      mem[bus.prog_addr[AW-1:0]] <= bus.prog_data;
    end
  end

  instr_decoder u_instr_decoder (
    .instruction (fetch_word),
    .ctrl        (fetch_ctrl)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= 8'h00;
      ctrl_q  <= CtrlBubble;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else if (bus.flush) begin
      instr_q <= 8'h00;
      ctrl_q  <= CtrlBubble;
      valid_q <= 1'b0;
    end else if (!bus.stall) begin
      instr_q <= fetch_word;
      ctrl_q  <= fetch_ctrl;
      valid_q <= 1'b1;
      if (cnt_q != '1) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.instruction = instr_q;
  assign bus.alu_op      = ctrl_q.alu_op;
  assign bus.reg_write   = ctrl_q.reg_write;
  assign bus.mem_to_reg  = ctrl_q.mem_to_reg;
  assign bus.mem_read    = ctrl_q.mem_read;
  assign bus.mem_write   = ctrl_q.mem_write;
  assign bus.alu_src     = ctrl_q.alu_src;
  assign bus.reg_dst     = ctrl_q.reg_dst;
  assign bus.branch      = ctrl_q.branch;
  assign bus.jump        = ctrl_q.jump;
  assign bus.valid       = valid_q;
  assign bus.fetch_count = cnt_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Bench for fetch_decode: directed table, random traffic against a reference model,
// and a small-counter instance for saturation and out-of-range fetch.
module tb_fetch_decode;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  fetch_decode_if #(.CNT_W(16)) bus ();
  fetch_decode_if #(.CNT_W(3))  sat_bus ();

  fetch_decode #(.IMEM_DEPTH(256), .CNT_W(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  fetch_decode #(.IMEM_DEPTH(16), .CNT_W(3)) u_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (sat_bus)
  );

  // Control vector order: alu_op[2:0], reg_write, mem_to_reg, mem_read, mem_write,
  // alu_src, reg_dst, branch, jump.
  localparam logic [10:0] C_ADD = {3'b000, 8'b1000_0100};
  localparam logic [10:0] C_SUB = {3'b001, 8'b1000_0100};
  localparam logic [10:0] C_AND = {3'b010, 8'b1000_0100};
  localparam logic [10:0] C_OR  = {3'b011, 8'b1000_0100};
  localparam logic [10:0] C_LW  = {3'b000, 8'b1110_1000};
  localparam logic [10:0] C_SW  = {3'b000, 8'b0001_1000};
  localparam logic [10:0] C_BEQ = {3'b001, 8'b0000_0010};
  localparam logic [10:0] C_J   = {3'b000, 8'b0000_0001};
  localparam logic [10:0] C_NOP = 11'h000;

  // Reference model state.
  logic [7:0]  m_mem [256];
  logic [7:0]  m_instr;
  logic        m_valid;
  logic [15:0] m_cnt;

  function automatic logic [10:0] ref_ctrl(input logic [7:0] ins);
    int op;
    logic [2:0] alu;
    op  = int'(ins[7:5]);
    alu = (op <= 3) ? 3'(op) : ((op == 6) ? 3'b001 : 3'b000);
    return {alu, (op <= 4), (op == 4), (op == 4), (op == 5), (op == 4 || op == 5), (op <= 3),
            (op == 6), (op == 7)};
  endfunction

  function automatic logic [10:0] dut_ctrl();
    return {bus.alu_op, bus.reg_write, bus.mem_to_reg, bus.mem_read, bus.mem_write,
            bus.alu_src, bus.reg_dst, bus.branch, bus.jump};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one clock edge, updating the model from the inputs present at that edge.
  task automatic cycle();
    logic [7:0] old_word;
    old_word = m_mem[bus.pc];
    if (reset) begin
      m_instr = 8'h00;
      m_valid = 1'b0;
      m_cnt   = 16'd0;
    end else if (bus.flush) begin
      m_instr = 8'h00;
      m_valid = 1'b0;
    end else if (!bus.stall) begin
      m_instr = old_word;
      m_valid = 1'b1;
      if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    if (bus.prog_we) m_mem[bus.prog_addr] = bus.prog_data;
    @(posedge clk);
    #1;
  endtask

  task automatic check_model();
    check("model_instruction", 32'(bus.instruction), 32'(m_instr));
    check("model_ctrl", 32'(dut_ctrl()), m_valid ? 32'(ref_ctrl(m_instr)) : 32'(0));
    check("model_valid", 32'(bus.valid), 32'(m_valid));
    check("model_fetch_count", 32'(bus.fetch_count), 32'(m_cnt));
  endtask

  typedef struct {
    logic        rst;
    logic        stall;
    logic        flush;
    logic        we;
    logic [7:0]  pc;
    logic [7:0]  waddr;
    logic [7:0]  wdata;
    logic [7:0]  e_instr;
    logic [10:0] e_ctrl;
    logic        e_valid;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic s, input logic f, input logic w,
                              input logic [7:0] pc, input logic [7:0] wa, input logic [7:0] wd,
                              input logic [7:0] ei, input logic [10:0] ec, input logic ev,
                              input logic [15:0] cnt);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.we = w; v.pc = pc; v.waddr = wa; v.wdata = wd;
    v.e_instr = ei; v.e_ctrl = ec; v.e_valid = ev; v.e_cnt = cnt;
    return v;
  endfunction

  vec_t vt [17];

  initial begin
    reset         = 1'b1;
    bus.pc        = 8'h00;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.prog_we   = 1'b0;
    bus.prog_addr = 8'h00;
    bus.prog_data = 8'h00;
    sat_bus.pc        = 8'h20;
    sat_bus.stall     = 1'b0;
    sat_bus.flush     = 1'b0;
    sat_bus.prog_we   = 1'b0;
    sat_bus.prog_addr = 8'h00;
    sat_bus.prog_data = 8'h00;
    m_instr = 8'h00;
    m_valid = 1'b0;
    m_cnt   = 16'd0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'h00;

    // Preload the whole memory while reset is held.
    for (int a = 0; a < 256; a++) begin
      logic [7:0] w;
      case (a)
        0: w = 8'h1D;
        1: w = 8'h85;
        2: w = 8'hA6;
        3: w = 8'hC9;
        4: w = 8'hE3;
        5: w = 8'h40;
        6: w = 8'h60;
        7: w = 8'h55;
        default: w = 8'($urandom);
      endcase
      bus.prog_we   = 1'b1;
      bus.prog_addr = 8'(a);
      bus.prog_data = w;
      cycle();
    end
    bus.prog_we = 1'b0;

    vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, C_NOP, 1'b0, 16'd0);
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h1D, C_ADD, 1'b1, 16'd1);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h85, C_LW,  1'b1, 16'd2);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 8'h00, 8'h00, 8'hA6, C_SW,  1'b1, 16'd3);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h03, 8'h00, 8'h00, 8'hC9, C_BEQ, 1'b1, 16'd4);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 8'h00, 8'h00, 8'hE3, C_J,   1'b1, 16'd5);
    vt[6]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'hE3, C_J,   1'b1, 16'd5);
    vt[7]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h06, 8'h00, 8'h00, 8'hE3, C_J,   1'b1, 16'd5);
    vt[8]  = mk(1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'hE3, C_J,   1'b1, 16'd5);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 8'h00, 8'h00, 8'h60, C_OR,  1'b1, 16'd6);
    vt[10] = mk(1'b0, 1'b1, 1'b1, 1'b0, 8'h05, 8'h00, 8'h00, 8'h00, C_NOP, 1'b0, 16'd6);
    vt[11] = mk(1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 8'h00, 8'h00, 8'h00, C_NOP, 1'b0, 16'd6);
    vt[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h05, 8'h00, 8'h00, 8'h40, C_AND, 1'b1, 16'd7);
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 8'h07, 8'h3F, 8'h55, C_AND, 1'b1, 16'd8);
    vt[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h07, 8'h00, 8'h00, 8'h3F, C_SUB, 1'b1, 16'd9);
    vt[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h00, C_NOP, 1'b0, 16'd0);
    vt[16] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h00, 8'h00, 8'h85, C_LW,  1'b1, 16'd1);

    for (int i = 0; i < 17; i++) begin
      reset         = vt[i].rst;
      bus.stall     = vt[i].stall;
      bus.flush     = vt[i].flush;
      bus.prog_we   = vt[i].we;
      bus.pc        = vt[i].pc;
      bus.prog_addr = vt[i].waddr;
      bus.prog_data = vt[i].wdata;
      cycle();
      check($sformatf("vec%0d_instruction", i), 32'(bus.instruction), 32'(vt[i].e_instr));
      check($sformatf("vec%0d_ctrl", i), 32'(dut_ctrl()), 32'(vt[i].e_ctrl));
      check($sformatf("vec%0d_valid", i), 32'(bus.valid), 32'(vt[i].e_valid));
      check($sformatf("vec%0d_fetch_count", i), 32'(bus.fetch_count), 32'(vt[i].e_cnt));
    end
    bus.prog_we = 1'b0;

    // Randomised traffic including same-address read/write and occasional reset.
    for (int n = 0; n < 400; n++) begin
      reset         = ($urandom_range(0, 99) < 3);
      bus.stall     = ($urandom_range(0, 99) < 25);
      bus.flush     = ($urandom_range(0, 99) < 12);
      bus.prog_we   = ($urandom_range(0, 99) < 20);
      bus.pc        = 8'($urandom);
      bus.prog_addr = ($urandom_range(0, 1) == 1) ? bus.pc : 8'($urandom);
      bus.prog_data = 8'($urandom);
      cycle();
      check_model();
    end

    // Saturation of a 3-bit counter, fetching past a 16-word memory.
    bus.stall   = 1'b0;
    bus.flush   = 1'b0;
    bus.prog_we = 1'b0;
    reset       = 1'b1;
    cycle();
    check_model();
    check("sat_reset_count", 32'(sat_bus.fetch_count), 32'(0));
    check("sat_reset_valid", 32'(sat_bus.valid), 32'(0));
    reset = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      bus.pc = 8'($urandom);
      cycle();
      check_model();
      check($sformatf("sat_count_%0d", k), 32'(sat_bus.fetch_count), 32'((k < 7) ? k : 7));
      check("oor_instruction", 32'(sat_bus.instruction), 32'(0));
      check("oor_valid", 32'(sat_bus.valid), 32'(1));
      check("oor_reg_write", 32'(sat_bus.reg_write), 32'(1));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
# fetch_decode

Front-end stage directly upstream of the 8-bit datapath. Holds the instruction memory, fetches the word addressed by the datapath's `pc`, decodes it, and presents instruction plus all datapath control signals from a registered IF/ID stage. Supports stall (hold) and flush (bubble insertion) for hazard and redirect handling, and a program-load port used by reset-time loaders and benches.

## Interface
- `IMEM_DEPTH`, 256: instruction memory words; addresses ≥ depth read as 8'h00.
- `CNT_W`, 16: width of fetch counter.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `pc`  in  8  fetch address from datapath.
- `stall`  in  1  hold IF/ID contents this cycle.
- `flush`  in  1  replace IF/ID contents with bubble (taken branch/jump).
- `prog_we`  in  1  instruction memory write enable.
- `prog_addr`  in  8  write address.
- `prog_data`  in  8  write data.
- `instruction`  out  8  registered instruction to datapath.
- `alu_op`  out  3  ALU operation.
- `reg_write`, `mem_to_reg`, `mem_read`, `mem_write`, `alu_src`, `reg_dst`, `branch`, `jump`  out  1 each  datapath controls.
- `valid`  out  1  IF/ID holds a real instruction.
- `fetch_count`  out  CNT_W  instructions accepted into IF/ID.

## Operation
- Encoding: opcode = `instruction[7:5]`; 000 ADD, 001 SUB, 010 AND, 011 OR, 100 LW, 101 SW, 110 BEQ, 111 J.
- ALU op codes: 000 add, 001 sub, 010 and, 011 or.
- Decode:
  - ADD/SUB/AND/OR: reg_write=1, reg_dst=1, alu_src=0, alu_op = opcode.
  - LW: reg_write, mem_to_reg, mem_read, alu_src =1; reg_dst=0; alu_op add.
  - SW: mem_write, alu_src =1; alu_op add.
  - BEQ: branch=1; alu_op sub.
  - J: jump=1; alu_op add.
  - All unlisted controls are 0.
- Bubble: instruction 8'h00, all controls 0, alu_op 000, valid 0.
- Per-cycle priority: reset > flush > stall > normal load.
  - Normal load: IF/ID ← mem[pc] plus decoded controls; valid=1; fetch_count+1.
  - Stall: all outputs hold; counter holds.
  - Flush: bubble; counter holds. Flush and stall together resolve as flush.
- fetch_count saturates at all-ones, no wrap.
- Memory write is synchronous on `prog_we`. It is independent of stall/flush and is not cleared by reset.

## Timing
- Reset: instruction 8'h00, all controls 0, alu_op 000, valid 0, fetch_count 0. Takes effect at the first rising edge with reset high. A mid-stream reset discards IF/ID contents.
- Latency: `pc` sampled at edge N appears decoded on outputs after edge N, i.e. a 1-cycle fetch.
- Memory read is combinational from the array, then registered.
- Read-during-write to the same address in the same cycle: fetch captures the OLD word; new word visible from the next cycle.
- `pc` ≥ IMEM_DEPTH fetches 8'h00 (ADD r0 encoding) with valid=1.
- Outputs depend only on registers. No combinational path from inputs to outputs.

## Structure
- Shared package `cpu_pkg`: opcode constants, ALU op constants, and a packed control struct (alu_op + 8 control bits). The datapath and hazard logic import the same package.
- One combinational sub-module `instr_decoder`: 8-bit instruction → control struct. The decoder sits before the IF/ID register so the register stores decoded controls.
- Top-level contents: memory array, IF/ID register, counter.

## Test plan
- Reset then release with mem[0]=8'h1D (ADD), pc=0 → next cycle instruction=8'h1D, reg_write=1, reg_dst=1, alu_op=000, valid=1, fetch_count=1.
- Load LW 8'h85, SW 8'hA6, BEQ 8'hC9, J 8'hE3 at pc 1..4, step pc → each decodes per table (LW: mem_read, mem_to_reg, alu_src, reg_write; BEQ: branch, alu_op=001; J: jump); fetch_count=5.
- Stall 3 cycles while pc changes → outputs and fetch_count frozen; on release, the word at the current pc loads.
- Assert flush and stall together → bubble (valid=0, controls 0); fetch_count unchanged.
- prog_we to address 7 with 8'h3F while pc=7 → same-cycle fetch returns old word; the following fetch returns 8'h3F.
- Reset asserted mid-stream with valid=1 → all outputs return to reset values at that edge. Memory contents survive; a re-fetch of a loaded address returns its data.
